memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
Shares one 32-bit memory bus between two requesters: requester 0 is the data port and requester 1 is the instruction-fetch port, e.g. for a pipelined core or core plus debug/DMA master. The arbiter performs one transaction at a time. It registers the winner's request, issues it on the bus, waits a fixed read latency, and returns a single-cycle ready pulse to the winner. It sits between the core's memory interfaces and the system bus/memory.

Parameters:
READ_LATENCY, 1, cycles from bus_read_enable asserted to bus_read_data valid; legal range 1..4.
ROUND_ROBIN, 1, 1 = alternate winner on contention; 0 = requester 0 always wins.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req0_address  input  32  requester 0 byte address
req0_write_data  input  32  requester 0 store data
req0_byte_enable  input  4  requester 0 byte lanes
req0_read_enable  input  1  requester 0 read request
req0_write_enable  input  1  requester 0 write request
req0_ready  output  1  requester 0 transaction complete (1-cycle pulse)
req0_read_data  output  32  requester 0 load data, valid with req0_ready
req1_address, req1_write_data, req1_byte_enable, req1_read_enable, req1_write_enable  input  32/32/4/1/1  requester 1, same as requester 0
req1_ready  output  1  requester 1 complete
req1_read_data  output  32  requester 1 load data
bus_address  output  32  memory address
bus_write_data  output  32  memory store data
bus_byte_enable  output  4  memory byte lanes
bus_read_enable  output  1  memory read strobe
bus_write_enable  output  1  memory write strobe
bus_read_data  input  32  memory read data

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE.
  - Wait counter goes to 0.
  - last_grant goes to 1, so requester 0 wins the first tie.
  - All outputs go to 0.
  - Reset mid-transaction abandons it; no ready pulse is issued.
- A request is pending when read_enable or write_enable is high. The requester holds address, data and enables stable until it samples its ready high.
- If both read_enable and write_enable are high, the request is treated as a write; read_enable is ignored.
- States:
  - IDLE: if any request is pending, choose the winner and capture its address, write data, byte enable and op (read/write) into registers; record the winner in grant; go to ISSUE. Otherwise stay in IDLE.
  - Winner selection: a single pending requester wins. On a tie, requester 0 wins when ROUND_ROBIN=0; when ROUND_ROBIN=1 the winner is the inverse of last_grant. last_grant updates on every capture.
  - ISSUE: drive bus_* from the captured registers for exactly one cycle.
    - Write: the winner's ready is high in this cycle; next state is IDLE.
    - Read: bus_read_enable is high in this cycle; load the wait counter with READ_LATENCY-1; next state is WAIT.
  - WAIT: the bus enables are 0 and the bus address/data hold their captured values. When the counter is 0, the winner's ready is high and its read_data equals bus_read_data in that same cycle; next state is IDLE. Otherwise decrement the counter.
- Timing:
  - A write completes 1 cycle after capture (2 cycles of bus occupancy).
  - A read completes READ_LATENCY cycles after ISSUE.
  - A new arbitration can occur in the cycle immediately after a ready pulse.
- A requester sees ready only for its own transaction; the loser's ready stays 0.
- req*_read_data is 0 except in that requester's read-completion cycle.
- The loser's request stays pending and is served in the next arbitration. ROUND_ROBIN=1 bounds its wait to one competing transaction.
- bus_read_enable and bus_write_enable are never high simultaneously, and never high outside ISSUE.

Optional Feature:
BUS_ARBITER_PERF_COUNTERS_EN
- Defined: adds outputs perf_grant0_count[31:0], perf_grant1_count[31:0] and perf_contention_count[31:0].
  - perf_grant0_count and perf_grant1_count increment on each capture for the respective requester.
  - perf_contention_count increments on every cycle where a requester is pending but is not the one being captured or served.
  - All counters reset to 0 and wrap modulo 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. Single read: req1 reads 0x0000_0100, memory returns 0xDEAD_BEEF, READ_LATENCY=1.
   - Expected: bus_read_enable high 1 cycle after the request; req1_ready and req1_read_data=0xDEAD_BEEF 1 cycle later; req0_ready stays 0.
2. Single write: req0 writes 0x1234_5678 to 0x0000_0200 with byte_enable=0x3.
   - Expected: bus_write_enable, bus_address=0x200, bus_write_data=0x12345678 and bus_byte_enable=0x3 for one cycle; req0_ready high in that same cycle.
3. Contention, ROUND_ROBIN=1: both requesters issue continuous reads from reset.
   - Expected: grant order 0,1,0,1; each requester receives exactly 2 ready pulses over 4 transactions.
4. Contention, ROUND_ROBIN=0: same stimulus.
   - Expected: requester 0 served every transaction; req1_ready stays 0 while req0 keeps requesting.
5. READ_LATENCY=3: req0 reads.
   - Expected: req0_ready exactly 3 cycles after bus_read_enable.
   - Then set read_enable and write_enable both high: a write is performed and exactly one ready pulse is issued.
6. Reset during WAIT with READ_LATENCY=3: assert reset 1 cycle after ISSUE.
   - Expected: all outputs 0 immediately; no ready pulse; after release, a pending req1 is captured in the first IDLE cycle.
   - With BUS_ARBITER_PERF_COUNTERS_EN defined: all counters read 0.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// Two-requester arbiter sharing one 32-bit memory bus, one transaction at a time.
// Optional performance counters are enabled by defining BUS_ARBITER_PERF_COUNTERS_EN.
module memory_bus_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ROUND_ROBIN  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_write_data,
    input  logic [3:0]  req0_byte_enable,
    input  logic        req0_read_enable,
    input  logic        req0_write_enable,
    output logic        req0_ready,
    output logic [31:0] req0_read_data,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_write_data,
    input  logic [3:0]  req1_byte_enable,
    input  logic        req1_read_enable,
    input  logic        req1_write_enable,
    output logic        req1_ready,
    output logic [31:0] req1_read_data,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic [31:0] bus_read_data
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_grant0_count,
    output logic [31:0] perf_grant1_count,
    output logic [31:0] perf_contention_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    state_t      state_reg, state_next;
    logic [1:0]  wait_count_reg;
    logic        last_grant_reg;
    logic        grant_reg;
    logic        op_write_reg;
    logic [31:0] address_reg;
    logic [31:0] write_data_reg;
    logic [3:0]  byte_enable_reg;

    logic [1:0]  pending;
    logic        winner;
    logic        capture;
    logic        done;
    logic        read_done;
    logic [1:0]  ready_vec;
    logic [31:0] read_data_vec [2];

    assign pending[0] = req0_read_enable | req0_write_enable;
    assign pending[1] = req1_read_enable | req1_write_enable;
    assign capture    = (state_reg == IDLE) && (pending != 2'b00);

    always_comb begin
        winner = pending[1];
        if (pending == 2'b11) begin
            winner = (ROUND_ROBIN != 0) ? ~last_grant_reg : 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            wait_count_reg  <= 2'd0;
            last_grant_reg  <= 1'b1;
            grant_reg       <= 1'b0;
            op_write_reg    <= 1'b0;
            address_reg     <= 32'd0;
            write_data_reg  <= 32'd0;
            byte_enable_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                grant_reg       <= winner;
                last_grant_reg  <= winner;
                // A write enable overrides a simultaneous read enable.
                op_write_reg    <= winner ? req1_write_enable : req0_write_enable;
                address_reg     <= winner ? req1_address : req0_address;
                write_data_reg  <= winner ? req1_write_data : req0_write_data;
                byte_enable_reg <= winner ? req1_byte_enable : req0_byte_enable;
            end
            if (state_reg == ISSUE && !op_write_reg) begin
                wait_count_reg <= WAIT_LOAD;
            end else if (state_reg == WAIT && wait_count_reg != 2'd0) begin
                wait_count_reg <= wait_count_reg - 2'd1;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        done             = 1'b0;
        read_done        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (capture) state_next = ISSUE;
            end
            ISSUE: begin
                if (op_write_reg) begin
                    bus_write_enable = 1'b1;
                    done             = 1'b1;
                    state_next       = IDLE;
                end else begin
                    bus_read_enable = 1'b1;
                    state_next      = WAIT;
                end
            end
            WAIT: begin
                if (wait_count_reg == 2'd0) begin
                    done       = 1'b1;
                    read_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and data stay on the bus between transactions; only the strobes qualify them.
    assign bus_address     = address_reg;
    assign bus_write_data  = write_data_reg;
    assign bus_byte_enable = byte_enable_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_requester
        assign ready_vec[gi]     = done && (grant_reg == 1'(gi));
        assign read_data_vec[gi] = (read_done && grant_reg == 1'(gi)) ? bus_read_data : 32'd0;
    end

    assign req0_ready     = ready_vec[0];
    assign req1_ready     = ready_vec[1];
    assign req0_read_data = read_data_vec[0];
    assign req1_read_data = read_data_vec[1];

`ifdef BUS_ARBITER_PERF_COUNTERS_EN
    logic [1:0] served;
    logic       contending;

    for (genvar gi = 0; gi < 2; gi++) begin : g_served
        assign served[gi] = (state_reg == IDLE) ? (capture && (winner == 1'(gi)))
                                                : (grant_reg == 1'(gi));
    end

    assign contending = |(pending & ~served);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grant0_count     <= 32'd0;
            perf_grant1_count     <= 32'd0;
            perf_contention_count <= 32'd0;
        end else begin
            if (capture && !winner) perf_grant0_count <= perf_grant0_count + 32'd1;
            if (capture && winner)  perf_grant1_count <= perf_grant1_count + 32'd1;
            if (contending)         perf_contention_count <= perf_contention_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order, bus issue and ready timing;
// a monitor process pops predictions and compares them with the arbiter outputs.
module tb_memory_bus_arbiter;

    localparam int LAT = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- main DUT: READ_LATENCY=3, ROUND_ROBIN=1 ----------------
    logic        reset;
    logic [31:0] req0_address, req0_write_data, req1_address, req1_write_data;
    logic [3:0]  req0_byte_enable, req1_byte_enable;
    logic        req0_read_enable, req0_write_enable, req1_read_enable, req1_write_enable;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_read_data, req1_read_data;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable, bus_write_enable;
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
    logic [31:0] perf_grant0_count, perf_grant1_count, perf_contention_count;
    logic [31:0] f_perf_grant0_count, f_perf_grant1_count, f_perf_contention_count;
`endif

    logic        act   [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_be  [2];
    logic        r_re  [2];
    logic        r_we  [2];

    assign req0_address      = r_addr[0];
    assign req0_write_data   = r_wdata[0];
    assign req0_byte_enable  = r_be[0];
    assign req0_read_enable  = r_re[0];
    assign req0_write_enable = r_we[0];
    assign req1_address      = r_addr[1];
    assign req1_write_data   = r_wdata[1];
    assign req1_byte_enable  = r_be[1];
    assign req1_read_enable  = r_re[1];
    assign req1_write_enable = r_we[1];

    logic [1:0]  rdy;
    logic [31:0] rdat [2];
    assign rdy     = {req1_ready, req0_ready};
    assign rdat[0] = req0_read_data;
    assign rdat[1] = req1_read_data;

    function automatic logic [31:0] mem_f(logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus_read_data = mem_f(bus_address);

    memory_bus_arbiter #(.READ_LATENCY(LAT), .ROUND_ROBIN(1)) dut (
        .clock(clock), .reset(reset),
        .req0_address(req0_address), .req0_write_data(req0_write_data),
        .req0_byte_enable(req0_byte_enable), .req0_read_enable(req0_read_enable),
        .req0_write_enable(req0_write_enable), .req0_ready(req0_ready),
        .req0_read_data(req0_read_data),
        .req1_address(req1_address), .req1_write_data(req1_write_data),
        .req1_byte_enable(req1_byte_enable), .req1_read_enable(req1_read_enable),
        .req1_write_enable(req1_write_enable), .req1_ready(req1_ready),
        .req1_read_data(req1_read_data),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_read_data(bus_read_data)
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
        , .perf_grant0_count(perf_grant0_count), .perf_grant1_count(perf_grant1_count),
        .perf_contention_count(perf_contention_count)
`endif
    );

    // ---------------- second DUT: READ_LATENCY=1, fixed priority ----------------
    logic        f_reset;
    logic        f_re0, f_re1;
    logic        f_ready0, f_ready1;
    logic [31:0] f_rdata0, f_rdata1;
    logic [31:0] f_bus_address, f_bus_write_data, f_bus_read_data;
    logic [3:0]  f_bus_byte_enable;
    logic        f_bus_read_enable, f_bus_write_enable;

    assign f_bus_read_data = mem_f(f_bus_address);

    memory_bus_arbiter #(.READ_LATENCY(1), .ROUND_ROBIN(0)) dut_fixed (
        .clock(clock), .reset(f_reset),
        .req0_address(32'h0000_0040), .req0_write_data(32'd0),
        .req0_byte_enable(4'hF), .req0_read_enable(f_re0),
        .req0_write_enable(1'b0), .req0_ready(f_ready0),
        .req0_read_data(f_rdata0),
        .req1_address(32'h0000_0080), .req1_write_data(32'd0),
        .req1_byte_enable(4'hF), .req1_read_enable(f_re1),
        .req1_write_enable(1'b0), .req1_ready(f_ready1),
        .req1_read_data(f_rdata1),
        .bus_address(f_bus_address), .bus_write_data(f_bus_write_data),
        .bus_byte_enable(f_bus_byte_enable), .bus_read_enable(f_bus_read_enable),
        .bus_write_enable(f_bus_write_enable), .bus_read_data(f_bus_read_data)
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
        , .perf_grant0_count(f_perf_grant0_count), .perf_grant1_count(f_perf_grant1_count),
        .perf_contention_count(f_perf_contention_count)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          who;
        int          issue_cyc;
        int          done_cyc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   free_at = 0;
    int   last_w  = 1;
    int   grants [2] = '{0, 0};

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    // One transaction at a time: a write occupies the bus for capture+issue, a read for
    // capture+issue+LAT; ties go to whichever requester was not granted last.
    task automatic model_step();
        logic p0, p1;
        int   w;
        exp_t e;
        if (reset || cyc < free_at) return;
        p0 = r_re[0] | r_we[0];
        p1 = r_re[1] | r_we[1];
        if (!(p0 || p1)) return;
        if (p0 && p1) w = 1 - last_w;
        else          w = p1 ? 1 : 0;
        last_w = w;
        grants[w]++;
        e.who       = w;
        e.wr        = r_we[w];
        e.addr      = r_addr[w];
        e.wdata     = r_wdata[w];
        e.be        = r_be[w];
        e.issue_cyc = cyc + 1;
        e.done_cyc  = e.wr ? cyc + 1 : cyc + 1 + LAT;
        e.rdata     = e.wr ? 32'd0 : mem_f(e.addr);
        free_at     = e.done_cyc + 1;
        sb.push_back(e);
    endtask

    task automatic new_req(int r, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                           logic re, logic we);
        r_addr[r]  = a;
        r_wdata[r] = d;
        r_be[r]    = be;
        r_re[r]    = re;
        r_we[r]    = we;
        act[r]     = 1'b1;
    endtask

    task automatic random_req(int r);
        int op;
        op = int'($urandom_range(0, 3));
        new_req(r, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)),
                op != 1, op == 1 || op == 3);
    endtask

    // mode 0: no new requests, 1: back-to-back reads, 2: random traffic
    task automatic advance(int mode);
        for (int r = 0; r < 2; r++) begin
            if (act[r] && rdy[r]) begin
                act[r]  = 1'b0;
                r_re[r] = 1'b0;
                r_we[r] = 1'b0;
            end
            if (!act[r]) begin
                if (mode == 1)
                    new_req(r, 32'h1000 + 32'(r) * 32'h100 + ($urandom & 32'hFC), 32'd0, 4'hF, 1'b1, 1'b0);
                else if (mode == 2 && $urandom_range(0, 2) != 0)
                    random_req(r);
            end
        end
    endtask

    task automatic tick(int mode);
        advance(mode);
        model_step();
        @(negedge clock);
    endtask

    task automatic drain(string name, int bound);
        int n;
        n = 0;
        while ((act[0] || act[1]) && n < bound) begin
            tick(0);
            n++;
        end
        vectors++;
        check({name, "_drained"}, {30'd0, act[1], act[0]}, 32'd0);
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; r_re[r] = 1'b0; r_we[r] = 1'b0;
        end
    endtask

    task automatic check_all_zero(string tag);
        vectors++;
        check({tag, "_bus_address"}, bus_address, 32'd0);
        check({tag, "_bus_write_data"}, bus_write_data, 32'd0);
        check({tag, "_bus_byte_enable"}, 32'(bus_byte_enable), 32'd0);
        check({tag, "_bus_strobes"}, {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
        check({tag, "_ready"}, {30'd0, rdy}, 32'd0);
        check({tag, "_read_data0"}, req0_read_data, 32'd0);
        check({tag, "_read_data1"}, req1_read_data, 32'd0);
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
        check({tag, "_perf_grant0"}, perf_grant0_count, 32'd0);
        check({tag, "_perf_grant1"}, perf_grant1_count, 32'd0);
        check({tag, "_perf_contention"}, perf_contention_count, 32'd0);
`endif
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        logic have;
        forever begin
            @(negedge clock);
            if (reset) continue;
            have = sb.size() > 0;
            if (have) e = sb[0];
            if (have && e.issue_cyc == cyc) begin
                vectors++;
                $display("issue  cycle %0d: req%0d %s addr=%h wdata=%h be=%h",
                         cyc, e.who, e.wr ? "write" : "read ", e.addr, e.wdata, e.be);
                check("bus_write_enable", 32'(bus_write_enable), 32'(e.wr));
                check("bus_read_enable", 32'(bus_read_enable), 32'(!e.wr));
                check("bus_address", bus_address, e.addr);
                check("bus_write_data", bus_write_data, e.wdata);
                check("bus_byte_enable", 32'(bus_byte_enable), 32'(e.be));
            end else begin
                check("bus_strobes_quiet", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
                if (have && cyc > e.issue_cyc) check("bus_address_hold", bus_address, e.addr);
            end
            if (have && e.done_cyc == cyc) begin
                vectors++;
                $display("ready  cycle %0d: req%0d read_data=%h", cyc, e.who, rdat[e.who]);
                check($sformatf("req%0d_ready", e.who), 32'(rdy[e.who]), 32'd1);
                check($sformatf("req%0d_ready_loser", 1 - e.who), 32'(rdy[1 - e.who]), 32'd0);
                check($sformatf("req%0d_read_data", e.who), rdat[e.who], e.rdata);
                check($sformatf("req%0d_read_data_loser", 1 - e.who), rdat[1 - e.who], 32'd0);
                void'(sb.pop_front());
            end else begin
                check("ready_unexpected", {30'd0, rdy}, 32'd0);
                check("read_data0_quiet", rdat[0], 32'd0);
                check("read_data1_quiet", rdat[1], 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        reset   = 1'b1;
        f_reset = 1'b1;
        f_re0   = 1'b0;
        f_re1   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            act[r] = 1'b0; r_addr[r] = 32'd0; r_wdata[r] = 32'd0;
            r_be[r] = 4'd0; r_re[r] = 1'b0; r_we[r] = 1'b0;
        end
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // single read by requester 1
        new_req(1, 32'h0000_0100, 32'd0, 4'hF, 1'b1, 1'b0);
        drain("single_read", 20);

        // single write by requester 0
        new_req(0, 32'h0000_0200, 32'h1234_5678, 4'h3, 1'b0, 1'b1);
        drain("single_write", 20);

        // both requesters stream reads: grants must alternate
        new_req(0, 32'h0000_1000, 32'd0, 4'hF, 1'b1, 1'b0);
        new_req(1, 32'h0000_1100, 32'd0, 4'hF, 1'b1, 1'b0);
        repeat (4 * (LAT + 2)) tick(1);
        drain("stream", 40);

        // read and write enables together behave as a write
        new_req(0, 32'h0000_0300, 32'hCAFE_F00D, 4'hC, 1'b1, 1'b1);
        drain("read_write_both", 20);

        // reset in the first WAIT cycle of a read, with requester 1 waiting
        new_req(0, 32'h0000_0400, 32'd0, 4'hF, 1'b1, 1'b0);
        tick(0);
        new_req(1, 32'h0000_0500, 32'd0, 4'hF, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            if (sb.size() > 0 && !sb[0].wr && cyc == sb[0].issue_cyc + 1) break;
            tick(0);
        end
        reset  = 1'b1;
        act[0] = 1'b0; r_re[0] = 1'b0; r_we[0] = 1'b0;
        sb.delete();
        free_at = 0;
        last_w  = 1;
        grants  = '{0, 0};
        #1;
        check_all_zero("reset_in_wait");
        repeat (2) begin
            @(negedge clock);
            vectors++;
            check("ready_during_reset", {30'd0, rdy}, 32'd0);
        end
        reset = 1'b0;
        drain("after_reset", 20);

        // random traffic
        repeat (800) tick(2);
        drain("random", 60);
        repeat (2) @(negedge clock);
        vectors++;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
`ifdef BUS_ARBITER_PERF_COUNTERS_EN
        vectors++;
        check("perf_grant0_total", perf_grant0_count, 32'(grants[0]));
        check("perf_grant1_total", perf_grant1_count, 32'(grants[1]));
`endif

        // fixed-priority instance: requester 0 wins every tie, one read per 3 cycles
        f_re0   = 1'b1;
        f_re1   = 1'b1;
        f_reset = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            logic exp0, exp1, exp_re;
            @(negedge clock);
            exp0   = (k < 15) && (k % 3 == 2);
            exp1   = (k == 17);
            exp_re = ((k < 15) && (k % 3 == 1)) || (k == 16);
            vectors++;
            $display("fixed  step %0d: ready0=%0b ready1=%0b bus_read_enable=%0b",
                     k, f_ready0, f_ready1, f_bus_read_enable);
            check("fixed_ready0", 32'(f_ready0), 32'(exp0));
            check("fixed_ready1", 32'(f_ready1), 32'(exp1));
            check("fixed_bus_read_enable", 32'(f_bus_read_enable), 32'(exp_re));
            check("fixed_bus_write_enable", 32'(f_bus_write_enable), 32'd0);
            check("fixed_read_data0", f_rdata0, exp0 ? mem_f(32'h0000_0040) : 32'd0);
            check("fixed_read_data1", f_rdata1, exp1 ? mem_f(32'h0000_0080) : 32'd0);
            if (k == 14) f_re0 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
